aes_wb_mailbox: RTL and testbench

Parametrised Wishbone front-end for the block-cipher core, replacing the direct core-to-bus hookup inside the user project wrapper. Holds key and input-block registers, launches encrypt/decrypt operations through a start/valid handshake, and buffers results in an output FIFO of configurable depth. The result FIFO decouples the management SoC from core latency and drives a level interrupt.

---
 rtl/aes_wb_mailbox_if.sv | 21 ++
 rtl/aes_wb_mailbox.sv | 181 ++++++++++++++++++
 tb/tb_aes_wb_mailbox.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_wb_mailbox_if.sv
// rtl/aes_wb_mailbox_if.sv - Wishbone classic bus bundle between the management SoC and the cipher mailbox
interface aes_wb_mailbox_if;
  logic        io_wbs_cyc_i;
  logic        io_wbs_stb_i;
  logic        io_wbs_we_i;
  logic [3:0]  io_wbs_sel_i;
  logic [31:0] io_wbs_adr_i;
  logic [31:0] io_wbs_dat_i;
  logic        io_wbs_ack_o;
  logic [31:0] io_wbs_dat_o;

  modport master (
    output io_wbs_cyc_i, io_wbs_stb_i, io_wbs_we_i, io_wbs_sel_i, io_wbs_adr_i, io_wbs_dat_i,
    input  io_wbs_ack_o, io_wbs_dat_o
  );

  modport slave (
    input  io_wbs_cyc_i, io_wbs_stb_i, io_wbs_we_i, io_wbs_sel_i, io_wbs_adr_i, io_wbs_dat_i,
    output io_wbs_ack_o, io_wbs_dat_o
  );
endinterface

// File: rtl/aes_wb_mailbox.sv
// rtl/aes_wb_mailbox.sv - Wishbone mailbox for the block-cipher core
// Key/input registers, start/valid launch FSM and a 128-bit result FIFO with level irq.
module aes_wb_mailbox #(
  parameter int KEY_W      = 128,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset,
  aes_wb_mailbox_if.slave    wb,
  output logic               core_start,
  output logic               core_mode,
  output logic [KEY_W-1:0]   core_key,
  output logic [127:0]       core_block,
  input  logic               core_valid,
  input  logic [127:0]       core_result,
  output logic               irq
);
  localparam int NK    = KEY_W / 32;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_PUSH} state_t;
  state_t state_q, state_d;

  logic             ack_q;
  logic [31:0]      dat_q;
  logic             mode_q, irq_en_q, err_q, start_pend_q, irq_q;
  logic [31:0]      key_q [NK];
  logic [31:0]      din_q [4];
  logic [127:0]     hold_q;
  logic [127:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q, wr_idx;
  logic [CNT_W-1:0] count_q, count_d;

  logic [5:0]       word_adr;
  logic [31:0]      wdata;
  logic [3:0]       sel;
  logic             req, wr, rd, busy, locked, empty, full;
  logic             wr_ctrl, wr_stat, start_req, start_ok, start_err, flush, pop, push, irq_en_d;
  logic [31:0]      rdata;
  logic [127:0]     head;
  logic             unused_adr;

  assign word_adr   = wb.io_wbs_adr_i[7:2];
  assign unused_adr = ^{wb.io_wbs_adr_i[31:8], wb.io_wbs_adr_i[1:0]};
  assign wdata      = wb.io_wbs_dat_i;
  assign sel        = wb.io_wbs_sel_i;

  assign req = wb.io_wbs_cyc_i & wb.io_wbs_stb_i & ~ack_q;
  assign wr  = req & wb.io_wbs_we_i;
  assign rd  = req & ~wb.io_wbs_we_i;

  assign busy  = (state_q != S_IDLE);
  // A START accepted but not yet launched already owns the core.
  assign locked = busy | start_pend_q;
  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(FIFO_DEPTH));

  assign wr_ctrl   = wr & (word_adr == 6'd0) & sel[0];
  assign wr_stat   = wr & (word_adr == 6'd1) & sel[0];
  assign start_req = wr_ctrl & wdata[0];
  assign start_ok  = start_req & ~locked;
  assign start_err = start_req & locked;
  assign flush     = wr_ctrl & wdata[3];
  assign pop       = rd & (word_adr == 6'd19) & ~empty;
  assign irq_en_d  = wr_ctrl ? wdata[2] : irq_en_q;

  assign head   = mem_q[rd_ptr_q];
  assign wr_idx = flush ? '0 : wr_ptr_q;

  assign wb.io_wbs_ack_o = ack_q;
  assign wb.io_wbs_dat_o = dat_q;
  assign core_mode       = mode_q;
  assign irq             = irq_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    core_start = 1'b0;
    push       = 1'b0;
    unique case (state_q)
      S_IDLE:   if (start_pend_q) state_d = S_LAUNCH;
      S_LAUNCH: begin
        core_start = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT:   if (core_valid) state_d = S_PUSH;
      // A full FIFO stalls here; the held result is written once a slot frees.
      S_PUSH:   if (!full || pop || flush) begin
        push    = 1'b1;
        state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (flush)              count_d = push ? CNT_W'(1) : '0;
    else if (push && !pop)  count_d = count_q + 1'b1;
    else if (pop && !push)  count_d = count_q - 1'b1;
  end

  always_comb begin
    rdata = '0;
    if (word_adr == 6'd0) rdata = {29'd0, irq_en_q, mode_q, 1'b0};
    if (word_adr == 6'd1) rdata = {16'd0, 8'(count_q), 3'd0, err_q, 1'b0, full, empty, busy};
    for (int i = 0; i < NK; i++)
      if (word_adr == 6'(4 + i)) rdata = key_q[i];
    for (int i = 0; i < 4; i++)
      if (word_adr == 6'(12 + i)) rdata = din_q[i];
    for (int i = 0; i < 4; i++)
      if (word_adr == 6'(16 + i) && !empty) rdata = head[32*i +: 32];
  end

  always_comb begin
    core_key   = '0;
    core_block = '0;
    for (int i = 0; i < NK; i++) core_key[32*i +: 32] = key_q[i];
    for (int i = 0; i < 4; i++)  core_block[32*i +: 32] = din_q[i];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ack_q        <= 1'b0;
      dat_q        <= '0;
      mode_q       <= 1'b0;
      irq_en_q     <= 1'b0;
      err_q        <= 1'b0;
      start_pend_q <= 1'b0;
      irq_q        <= 1'b0;
      for (int i = 0; i < NK; i++) key_q[i] <= '0;
      for (int i = 0; i < 4; i++)  din_q[i] <= '0;
    end else begin
      ack_q        <= req;
      dat_q        <= rd ? rdata : '0;
      start_pend_q <= start_ok;
      // Computed from next-state values so irq tracks the count in the same cycle.
      irq_q        <= irq_en_d & (count_d != '0);
      if (wr_ctrl) begin
        irq_en_q <= wdata[2];
        if (!locked) mode_q <= wdata[1];
      end
      if (start_err)                err_q <= 1'b1;
      else if (wr_stat && wdata[4]) err_q <= 1'b0;
      for (int i = 0; i < NK; i++)
        if (wr && !locked && word_adr == 6'(4 + i))
          for (int b = 0; b < 4; b++)
            if (sel[b]) key_q[i][8*b +: 8] <= wdata[8*b +: 8];
      for (int i = 0; i < 4; i++)
        if (wr && !locked && word_adr == 6'(12 + i))
          for (int b = 0; b < 4; b++)
            if (sel[b]) din_q[i][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (state_q == S_WAIT && core_valid) hold_q <= core_result;
      if (push) mem_q[wr_idx] <= hold_q;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= push ? PTR_W'(1) : '0;
      end else begin
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_aes_wb_mailbox.sv
// tb/tb_aes_wb_mailbox.sv - directed self-checking bench for aes_wb_mailbox
module tb_aes_wb_mailbox;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  int          dev = 0;

  aes_wb_mailbox_if wb0();
  aes_wb_mailbox_if wb1();

  assign wb0.io_wbs_cyc_i = cyc && (dev == 0);
  assign wb0.io_wbs_stb_i = stb && (dev == 0);
  assign wb0.io_wbs_we_i  = we;
  assign wb0.io_wbs_sel_i = sel;
  assign wb0.io_wbs_adr_i = adr;
  assign wb0.io_wbs_dat_i = wdat;
  assign wb1.io_wbs_cyc_i = cyc && (dev == 1);
  assign wb1.io_wbs_stb_i = stb && (dev == 1);
  assign wb1.io_wbs_we_i  = we;
  assign wb1.io_wbs_sel_i = sel;
  assign wb1.io_wbs_adr_i = adr;
  assign wb1.io_wbs_dat_i = wdat;

  logic         core_start0, core_mode0, irq0;
  logic [127:0] core_key0, core_block0;
  logic         core_valid = 1'b0;
  logic [127:0] res_val = '0;

  logic         core_start1, core_mode1, irq1;
  logic [255:0] core_key1;
  logic [127:0] core_block1;

  aes_wb_mailbox #(.KEY_W(128), .FIFO_DEPTH(4)) u_dut (
    .clock(clock), .reset(reset), .wb(wb0.slave),
    .core_start(core_start0), .core_mode(core_mode0), .core_key(core_key0),
    .core_block(core_block0), .core_valid(core_valid), .core_result(res_val), .irq(irq0)
  );

  aes_wb_mailbox #(.KEY_W(256), .FIFO_DEPTH(4)) u_dut256 (
    .clock(clock), .reset(reset), .wb(wb1.slave),
    .core_start(core_start1), .core_mode(core_mode1), .core_key(core_key1),
    .core_block(core_block1), .core_valid(1'b0), .core_result(128'h0), .irq(irq1)
  );

  // Core model and event log, evaluated mid-cycle.
  int cyc_n = 0, lat_cnt = 0, core_lat = 10;
  int start_cnt = 0, start_cyc = 0, valid_n = 0, valid_cyc = 0, irq_rise_cyc = 0, ack_cyc = 0;
  logic irq_prev = 1'b0;
  always @(negedge clock) begin
    cyc_n = cyc_n + 1;
    core_valid = 1'b0;
    if (lat_cnt > 0) begin
      lat_cnt = lat_cnt - 1;
      if (lat_cnt == 0) begin
        core_valid = 1'b1;
        valid_n    = valid_n + 1;
        valid_cyc  = cyc_n;
      end
    end
    if (core_start0 === 1'b1) begin
      start_cnt = start_cnt + 1;
      start_cyc = cyc_n;
      lat_cnt   = core_lat;
    end
    if (irq0 === 1'b1 && irq_prev === 1'b0) irq_rise_cyc = cyc_n;
    irq_prev = irq0;
    if (wb0.io_wbs_ack_o === 1'b1) ack_cyc = cyc_n;
  end

  task automatic wb_xfer(input int d, input logic w, input logic [31:0] a,
                         input logic [31:0] dt, input logic [3:0] s, output logic [31:0] rdat);
    bit got = 0;
    rdat = '0;
    @(posedge clock); #1;
    dev = d; cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = dt; sel = s;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clock); #1;
      if ((d == 0 ? wb0.io_wbs_ack_o : wb1.io_wbs_ack_o) === 1'b1) begin
        got  = 1;
        rdat = (d == 0) ? wb0.io_wbs_dat_o : wb1.io_wbs_dat_o;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got) begin
      total++; bad++;
      $display("FAIL wb_ack_timeout adr=%h got=no_ack need=ack", a);
    end
  endtask

  task automatic wr(input int d, input logic [31:0] a, input logic [31:0] dt, input logic [3:0] s);
    logic [31:0] dummy;
    wb_xfer(d, 1'b1, a, dt, s, dummy);
  endtask

  task automatic rd(input int d, input logic [31:0] a, output logic [31:0] r);
    wb_xfer(d, 1'b0, a, 32'h0, 4'hF, r);
  endtask

  task automatic wait_idle();
    logic [31:0] s = '0;
    bit idle = 0;
    for (int i = 0; i < 60 && !idle; i++) begin
      rd(0, 32'h04, s);
      idle = !s[0];
    end
    if (!idle) begin
      total++; bad++;
      $display("FAIL wait_idle got=%h need=busy_clear", s);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    repeat (3) @(negedge clock);
    #1;
    total++;
    if ({wb0.io_wbs_ack_o, wb0.io_wbs_dat_o, core_start0, core_mode0, core_key0, core_block0, irq0} !== '0) begin
      bad++; $display("FAIL reset_outputs got=nonzero need=all_zero");
    end
    total++;
    if ({wb1.io_wbs_ack_o, wb1.io_wbs_dat_o, core_start1, core_mode1, core_key1, core_block1, irq1} !== '0) begin
      bad++; $display("FAIL reset_outputs_256 got=nonzero need=all_zero");
    end
    @(negedge clock); reset = 1'b1;
    rd(0, 32'h04, r);
    total++;
    if (r !== 32'h0000_0002) begin bad++; $display("FAIL reset_status got=%h need=%h", r, 32'h2); end
  endtask

  task automatic test_encrypt();
    logic [31:0] r;
    int s0, t0;
    logic [31:0] exp_out [4];
    exp_out[0] = 32'h2466ef97; exp_out[1] = 32'ha89ecaf3;
    exp_out[2] = 32'h0d7a3660; exp_out[3] = 32'h3ad77bb4;
    wr(0, 32'h10, 32'h09cf4f3c, 4'hF); wr(0, 32'h14, 32'habf71588, 4'hF);
    wr(0, 32'h18, 32'h28aed2a6, 4'hF); wr(0, 32'h1C, 32'h2b7e1516, 4'hF);
    wr(0, 32'h30, 32'h7393172a, 4'hF); wr(0, 32'h34, 32'he93d7e11, 4'hF);
    wr(0, 32'h38, 32'h2e409f96, 4'hF); wr(0, 32'h3C, 32'h6bc1bee2, 4'hF);
    total++;
    if (core_key0 !== 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c) begin
      bad++; $display("FAIL enc_core_key got=%h need=2b7e1516...", core_key0);
    end
    total++;
    if (core_block0 !== 128'h6bc1bee2_2e409f96_e93d7e11_7393172a) begin
      bad++; $display("FAIL enc_core_block got=%h need=6bc1bee2...", core_block0);
    end
    res_val  = 128'h3ad77bb4_0d7a3660_a89ecaf3_2466ef97;
    core_lat = 10;
    s0 = start_cnt;
    wr(0, 32'h00, 32'h5, 4'hF);
    @(negedge clock); #1;
    t0 = ack_cyc;
    for (int i = 0; i < 40 && irq0 !== 1'b1; i++) @(negedge clock);
    #1;
    total++;
    if (irq0 !== 1'b1) begin bad++; $display("FAIL enc_irq_timeout got=%b need=1", irq0); end
    repeat (3) @(negedge clock);
    total++;
    if (start_cnt - s0 != 1) begin bad++; $display("FAIL enc_start_pulses got=%0d need=1", start_cnt - s0); end
    total++;
    if (start_cyc - t0 != 1) begin bad++; $display("FAIL enc_start_latency got=%0d need=1", start_cyc - t0); end
    total++;
    if (irq_rise_cyc - valid_cyc != 2) begin
      bad++; $display("FAIL enc_irq_latency got=%0d need=2", irq_rise_cyc - valid_cyc);
    end
    total++;
    if (core_mode0 !== 1'b0) begin bad++; $display("FAIL enc_mode got=%b need=0", core_mode0); end
    rd(0, 32'h04, r);
    total++;
    if (r !== 32'h0000_0100) begin bad++; $display("FAIL enc_status got=%h need=%h", r, 32'h100); end
    for (int i = 0; i < 4; i++) begin
      rd(0, 32'h40 + 32'(4 * i), r);
      total++;
      if (r !== exp_out[i]) begin bad++; $display("FAIL enc_dout%0d got=%h need=%h", i, r, exp_out[i]); end
    end
    @(negedge clock); #1;
    total++;
    if (irq0 !== 1'b0) begin bad++; $display("FAIL enc_irq_after_pop got=%b need=0", irq0); end
    rd(0, 32'h04, r);
    total++;
    if (r !== 32'h0000_0002) begin bad++; $display("FAIL enc_status_empty got=%h need=%h", r, 32'h2); end
    rd(0, 32'h40, r);
    total++;
    if (r !== 32'h0) begin bad++; $display("FAIL enc_dout_empty got=%h need=0", r); end
  endtask

  task automatic test_unmapped();
    logic [31:0] r;
    wr(0, 32'h20, 32'hdeadbeef, 4'hF);
    rd(0, 32'h20, r);
    total++;
    if (r !== 32'h0) begin bad++; $display("FAIL unmap_key4 got=%h need=0", r); end
    wr(0, 32'h50, 32'hdeadbeef, 4'hF);
    rd(0, 32'h50, r);
    total++;
    if (r !== 32'h0) begin bad++; $display("FAIL unmap_0x50 got=%h need=0", r); end
    wr(0, 32'h00, 32'h6, 4'h1);
    wr(0, 32'h00, 32'h0, 4'hE);
    rd(0, 32'h00, r);
    total++;
    if (r !== 32'h6) begin bad++; $display("FAIL ctrl_lane0_only got=%h need=%h", r, 32'h6); end
    total++;
    if (core_mode0 !== 1'b1) begin bad++; $display("FAIL ctrl_mode_out got=%b need=1", core_mode0); end
    wr(0, 32'h00, 32'h0, 4'h1);
  endtask

  task automatic test_fifo_full();
    logic [31:0] r;
    core_lat = 3;
    for (int k = 0; k <= 4; k++) begin
      res_val = {4{32'h1000_0000 + 32'(k)}};
      wr(0, 32'h00, 32'h1, 4'hF);
      if (k < 4) wait_idle();
    end
    repeat (12) @(negedge clock);
    rd(0, 32'h04, r);
    total++;
    if (r !== 32'h0000_0405) begin bad++; $display("FAIL full_hold_status got=%h need=%h", r, 32'h405); end
    rd(0, 32'h4C, r);
    total++;
    if (r !== 32'h1000_0000) begin bad++; $display("FAIL full_pop_head got=%h need=%h", r, 32'h1000_0000); end
    rd(0, 32'h04, r);
    total++;
    if (r !== 32'h0000_0404) begin bad++; $display("FAIL full_after_pop got=%h need=%h", r, 32'h404); end
    for (int k = 1; k <= 4; k++) begin
      rd(0, 32'h40, r);
      total++;
      if (r !== 32'h1000_0000 + 32'(k)) begin bad++; $display("FAIL full_order%0d got=%h need=%h", k, r, 32'h1000_0000 + 32'(k)); end
      rd(0, 32'h4C, r);
    end
    rd(0, 32'h04, r);
    total++;
    if (r !== 32'h0000_0002) begin bad++; $display("FAIL full_drained got=%h need=%h", r, 32'h2); end
  endtask

  task automatic test_start_busy();
    logic [31:0] r;
    int s0;
    core_lat = 10;
    res_val  = {4{32'h2222_2222}};
    s0 = start_cnt;
    wr(0, 32'h00, 32'h1, 4'hF);
    wr(0, 32'h00, 32'h1, 4'hF);
    wr(0, 32'h30, 32'h0, 4'hF);
    rd(0, 32'h04, r);
    total++;
    if ((r & 32'h11) !== 32'h11) begin bad++; $display("FAIL busy_err_set got=%h need=busy+err", r); end
    wait_idle();
    total++;
    if (start_cnt - s0 != 1) begin bad++; $display("FAIL busy_single_start got=%0d need=1", start_cnt - s0); end
    rd(0, 32'h04, r);
    total++;
    if (r !== 32'h0000_0110) begin bad++; $display("FAIL busy_status got=%h need=%h", r, 32'h110); end
    rd(0, 32'h30, r);
    total++;
    if (r !== 32'h7393172a) begin bad++; $display("FAIL busy_din_locked got=%h need=%h", r, 32'h7393172a); end
    wr(0, 32'h04, 32'h10, 4'hF);
    rd(0, 32'h04, r);
    total++;
    if (r !== 32'h0000_0100) begin bad++; $display("FAIL err_clear got=%h need=%h", r, 32'h100); end
    rd(0, 32'h4C, r);
    total++;
    if (r !== 32'h2222_2222) begin bad++; $display("FAIL busy_result got=%h need=%h", r, 32'h2222_2222); end
  endtask

  task automatic test_flush();
    logic [31:0] r;
    core_lat = 3;
    res_val = {4{32'h3000_0001}}; wr(0, 32'h00, 32'h1, 4'hF); wait_idle();
    res_val = {4{32'h3000_0002}}; wr(0, 32'h00, 32'h1, 4'hF); wait_idle();
    rd(0, 32'h04, r);
    total++;
    if (r !== 32'h0000_0200) begin bad++; $display("FAIL flush_pre got=%h need=%h", r, 32'h200); end
    core_lat = 15;
    res_val = {4{32'h3000_0003}};
    wr(0, 32'h00, 32'h1, 4'hF);
    wr(0, 32'h00, 32'h8, 4'hF);
    rd(0, 32'h04, r);
    total++;
    if (r !== 32'h0000_0003) begin bad++; $display("FAIL flush_now got=%h need=%h", r, 32'h3); end
    wait_idle();
    rd(0, 32'h04, r);
    total++;
    if (r !== 32'h0000_0100) begin bad++; $display("FAIL flush_after got=%h need=%h", r, 32'h100); end
    rd(0, 32'h4C, r);
    total++;
    if (r !== 32'h3000_0003) begin bad++; $display("FAIL flush_entry got=%h need=%h", r, 32'h3000_0003); end
  endtask

  task automatic test_key256();
    logic [31:0] r, exp_w;
    logic [255:0] exp_key = '0;
    for (int i = 0; i < 8; i++) wr(1, 32'h10 + 32'(4 * i), 32'hFFFF_FFFF, 4'hF);
    for (int i = 0; i < 8; i++)
      wr(1, 32'h10 + 32'(4 * i), {8'(8'hA0 + i), 8'(8'hB0 + i), 8'(8'hC0 + i), 8'(8'hD0 + i)}, 4'b0101);
    for (int i = 0; i < 8; i++) begin
      exp_w = {8'hFF, 8'(8'hB0 + i), 8'hFF, 8'(8'hD0 + i)};
      exp_key[32*i +: 32] = exp_w;
      rd(1, 32'h10 + 32'(4 * i), r);
      total++;
      if (r !== exp_w) begin bad++; $display("FAIL key256_word%0d got=%h need=%h", i, r, exp_w); end
    end
    total++;
    if (core_key1 !== exp_key) begin bad++; $display("FAIL key256_core_key got=%h need=%h", core_key1, exp_key); end
    total++;
    if ({core_start1, core_mode1, core_block1, irq1} !== '0) begin
      bad++; $display("FAIL key256_idle_outputs got=nonzero need=zero");
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int v0;
    core_lat = 10;
    res_val  = {4{32'h4444_4444}};
    v0 = valid_n;
    wr(0, 32'h00, 32'h7, 4'hF);
    repeat (4) @(negedge clock);
    #1;
    total++;
    if (core_mode0 !== 1'b1) begin bad++; $display("FAIL rmid_mode got=%b need=1", core_mode0); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    total++;
    if ({wb0.io_wbs_ack_o, wb0.io_wbs_dat_o, core_start0, core_mode0, core_key0, core_block0, irq0} !== '0) begin
      bad++; $display("FAIL rmid_outputs got=nonzero need=all_zero");
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (15) @(negedge clock);
    total++;
    if (valid_n - v0 != 1) begin bad++; $display("FAIL rmid_valid_seen got=%0d need=1", valid_n - v0); end
    rd(0, 32'h04, r);
    total++;
    if (r !== 32'h0000_0002) begin bad++; $display("FAIL rmid_status got=%h need=%h", r, 32'h2); end
    total++;
    if (irq0 !== 1'b0) begin bad++; $display("FAIL rmid_irq got=%b need=0", irq0); end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_unmapped();
    test_fifo_full();
    test_start_busy();
    test_flush();
    test_key256();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
